// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_AW   = 5;
    localparam int NUM_REGS = 2 ** DEF_AW;

    // Requester indices into the valid/grant vectors
    localparam int REQ_ALU  = 0;
    localparam int REQ_LD   = 1;

    // Register 0 is hard-wired zero; writes and claims to it are dropped
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, claim/hazard and register-file write bus.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
);
    logic                 claim_valid;
    logic [AW-1:0]        claim_rd;
    logic [AW-1:0]        ra;
    logic [AW-1:0]        rb;
    logic                 stall;

    logic                 req0_valid;
    logic [AW-1:0]        req0_rd;
    logic [XLEN-1:0]      req0_data;
    logic                 req0_ready;

    logic                 req1_valid;
    logic [AW-1:0]        req1_rd;
    logic [XLEN-1:0]      req1_data;
    logic                 req1_ready;

    logic                 we;
    logic [AW-1:0]        rw;
    logic [XLEN-1:0]      busw;
    logic [(2**AW)-1:0]   busy;

    // Pipeline side: issue claims/reads and presents writeback requests
    modport master (
        output claim_valid, claim_rd, ra, rb,
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        input  stall, req0_ready, req1_ready, we, rw, busw, busy
    );

    // Arbiter side
    modport slave (
        input  claim_valid, claim_rd, ra, rb,
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        output stall, req0_ready, req1_ready, we, rw, busw, busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses the next contention.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic r_rr_last;

    // Grant is combinational; nothing is granted while in reset
    always_comb begin
        grant         = 2'b00;
        grant[REQ_ALU] = !rst && valid[REQ_ALU] && (!valid[REQ_LD]  ||  r_rr_last);
        grant[REQ_LD]  = !rst && valid[REQ_LD]  && (!valid[REQ_ALU] || !r_rr_last);
    end

    // Remember the most recent winner; reset favours req0 for the first contention
    always_ff @(posedge clk) begin
        if (rst)
            r_rr_last <= 1'b1;
        else if (|grant)
            r_rr_last <= grant[REQ_LD];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: arbitrates ALU and load writebacks,
// registers the winning write and tracks pending writes for hazard stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int NR = 2 ** AW;
    localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

    logic [1:0]      w_valid;
    logic [1:0]      w_grant;
    logic            w_gnt_any;
    logic [AW-1:0]   w_gnt_rd;
    logic [XLEN-1:0] w_gnt_data;
    logic [NR-1:0]   w_busy_nxt;
    logic            w_haz_a;
    logic            w_haz_b;

    logic            r_we;
    logic [AW-1:0]   r_rw;
    logic [XLEN-1:0] r_busw;
    logic [NR-1:0]   r_busy;

    assign w_valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (w_valid),
        .grant (w_grant)
    );

    assign bus.req0_ready = w_grant[REQ_ALU];
    assign bus.req1_ready = w_grant[REQ_LD];
    assign w_gnt_any      = |w_grant;
    assign w_gnt_rd       = w_grant[REQ_LD] ? bus.req1_rd   : bus.req0_rd;
    assign w_gnt_data     = w_grant[REQ_LD] ? bus.req1_data : bus.req0_data;

    // Scoreboard next state: clear on grant first, then a claim re-sets (new producer wins)
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_gnt_any && w_gnt_rd != ZERO)
            w_busy_nxt[w_gnt_rd] = 1'b0;
        if (bus.claim_valid && bus.claim_rd != ZERO)
            w_busy_nxt[bus.claim_rd] = 1'b1;
    end

    // Write-port and scoreboard registers; rd=0 grants are consumed but never written
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_rw   <= '0;
            r_busw <= '0;
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_gnt_any && w_gnt_rd != ZERO) begin
                r_we   <= 1'b1;
                r_rw   <= w_gnt_rd;
                r_busw <= w_gnt_data;
            end else begin
                r_we   <= 1'b0;
            end
        end
    end

    // The we/rw term covers the cycle before the register file latches the write
    assign w_haz_a = (bus.ra != ZERO) && (r_busy[bus.ra] || (r_we && r_rw == bus.ra));
    assign w_haz_b = (bus.rb != ZERO) && (r_busy[bus.rb] || (r_we && r_rw == bus.rb));

    assign bus.stall = w_haz_a || w_haz_b;
    assign bus.we    = r_we;
    assign bus.rw    = r_rw;
    assign bus.busw  = r_busw;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed checks of regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(32), .AW(5)) bus();

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: set of pending registers, last winner, last write
    bit [31:0] m_busy;
    int        m_last;
    bit        m_we;
    bit [4:0]  m_rw;
    bit [31:0] m_busw;
    int        last_g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit pending(input bit [4:0] r);
        return (r != 0) && (m_busy[r] || (m_we && m_rw == r));
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic cycle();
        int g;
        #1;
        if (rst)                                  g = -1;
        else if (bus.req0_valid && bus.req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (bus.req0_valid)                  g = 0;
        else if (bus.req1_valid)                  g = 1;
        else                                      g = -1;
        check("ready0", 64'(bus.req0_ready), 64'(g == 0));
        check("ready1", 64'(bus.req1_ready), 64'(g == 1));
        check("stall",  64'(bus.stall), 64'(pending(bus.ra) || pending(bus.rb)));
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_last = 1; m_we = 0; m_rw = 0; m_busw = 0;
        end else begin
            bit [4:0]  rd;
            bit [31:0] d;
            rd = (g == 1) ? bus.req1_rd   : bus.req0_rd;
            d  = (g == 1) ? bus.req1_data : bus.req0_data;
            m_we = 0;
            if (g >= 0) begin
                m_last = g;
                if (rd != 0) begin
                    m_we = 1; m_rw = rd; m_busw = d; m_busy[rd] = 0;
                end
            end
            if (bus.claim_valid && bus.claim_rd != 0) m_busy[bus.claim_rd] = 1;
        end
        #1;
        check("we",   64'(bus.we),   64'(m_we));
        check("rw",   64'(bus.rw),   64'(m_rw));
        check("busw", 64'(bus.busw), 64'(m_busw));
        check("busy", 64'(bus.busy), 64'(m_busy));
        last_g = g;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req0_valid = 0; bus.req1_valid = 0; bus.claim_valid = 0;
        bus.claim_rd = 0; bus.ra = 0; bus.rb = 0;
    endtask

    initial begin
        idle();
        bus.req0_rd = 0; bus.req0_data = 0; bus.req1_rd = 0; bus.req1_data = 0;
        m_busy = 0; m_last = 1; m_we = 0; m_rw = 0; m_busw = 0; last_g = -1;
        @(negedge clk);

        // Reset held with both requesters valid
        bus.req0_valid = 1; bus.req0_rd = 3; bus.req0_data = 32'h11111111;
        bus.req1_valid = 1; bus.req1_rd = 4; bus.req1_data = 32'h22222222;
        repeat (2) cycle();
        check("rst_ready0", 64'(bus.req0_ready), 64'(0));
        check("rst_busy",   64'(bus.busy), 64'(0));
        rst = 0;

        // Continuous contention alternates req0, req1
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("cont_we", 64'(bus.we), 64'(1));
            check("cont_rw", 64'(bus.rw), 64'((i % 2 == 0) ? 3 : 4));
        end

        // Scoreboard set via claim, clear via grant, stall held through we/rw
        idle(); bus.claim_valid = 1; bus.claim_rd = 7;
        cycle();
        bus.claim_valid = 0; bus.ra = 7;
        cycle();
        check("sb_stall_set", 64'(bus.stall), 64'(1));
        bus.req1_valid = 1; bus.req1_rd = 7; bus.req1_data = 32'hDEADBEEF;
        cycle();
        check("sb_busy7_clr", 64'(bus.busy[7]), 64'(0));
        check("sb_stall_we",  64'(bus.stall), 64'(1));
        check("sb_busw",      64'(bus.busw), 64'(32'hDEADBEEF));
        bus.req1_valid = 0;
        cycle();
        check("sb_stall_drop", 64'(bus.stall), 64'(0));

        // Register 0: claim and write both dropped
        idle(); bus.claim_valid = 1; bus.claim_rd = 0;
        bus.req0_valid = 1; bus.req0_rd = 0; bus.req0_data = 32'hFFFFFFFF;
        #1 check("zero_ready0", 64'(bus.req0_ready), 64'(1));
        cycle();
        check("zero_we",    64'(bus.we), 64'(0));
        check("zero_busy",  64'(bus.busy), 64'(0));
        check("zero_stall", 64'(bus.stall), 64'(0));

        // Same-cycle claim and clear of register 9: set wins
        idle(); bus.claim_valid = 1; bus.claim_rd = 9;
        cycle();
        bus.req0_valid = 1; bus.req0_rd = 9; bus.req0_data = 32'h0000_0909;
        cycle();
        check("same_busy9", 64'(bus.busy[9]), 64'(1));
        check("same_we",    64'(bus.we), 64'(1));
        check("same_rw",    64'(bus.rw), 64'(9));

        // Reset right after a grant discards the registered write
        idle(); bus.req0_valid = 1; bus.req0_rd = 5; bus.req0_data = 32'h5555_5555;
        cycle();
        rst = 1;
        cycle();
        check("rstmid_we",   64'(bus.we), 64'(0));
        check("rstmid_busy", 64'(bus.busy), 64'(0));
        rst = 0; idle();

        // Random traffic; a stalled requester holds rd/data stable
        for (int i = 0; i < 400; i++) begin
            if (!(bus.req0_valid && last_g != 0)) begin
                bus.req0_valid = ($urandom_range(0, 3) != 0);
                bus.req0_rd    = 5'($urandom_range(0, 15));
                bus.req0_data  = $urandom;
            end
            if (!(bus.req1_valid && last_g != 1)) begin
                bus.req1_valid = ($urandom_range(0, 3) != 0);
                bus.req1_rd    = 5'($urandom_range(0, 15));
                bus.req1_data  = $urandom;
            end
            bus.claim_valid = ($urandom_range(0, 1) != 0);
            bus.claim_rd    = 5'($urandom_range(0, 15));
            bus.ra          = 5'($urandom_range(0, 15));
            bus.rb          = 5'($urandom_range(0, 15));
            rst             = ($urandom_range(0, 59) == 0);
            cycle();
            if (rst) begin
                rst = 0;
                bus.req0_valid = 0; bus.req1_valid = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32 × 32-bit register file, which has one write port.
- Shares that port between two writeback requesters: ALU (req0) and load unit (req1), using round-robin arbitration.
- Registers the winning write onto busw/rw/we.
- Keeps a pending-write scoreboard so issue logic can stall readers of registers that are still in flight.
- Sits between the execute/memory stages and the register file.

## Interface
Parameters:
- XLEN, 32, data width of busw and of the request data ports
- AW, 5, register address width (2^AW registers; register 0 is hard-wired zero)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- claim_valid  in  1  issue stage reserves a destination register
- claim_rd  in  AW  register being reserved
- ra  in  AW  read address A, checked for hazards
- rb  in  AW  read address B, checked for hazards
- stall  out  1  ra or rb has a pending write (combinational)
- req0_valid  in  1  ALU writeback request
- req0_rd  in  AW  ALU destination register
- req0_data  in  XLEN  ALU result
- req0_ready  out  1  ALU request accepted this cycle
- req1_valid, req1_rd, req1_data, req1_ready  same as req0, for the load unit
- we  out  1  register-file write enable (registered)
- rw  out  AW  register-file write address (registered)
- busw  out  XLEN  register-file write data (registered)
- busy  out  2^AW  scoreboard vector; bit i = write to register i pending

## Operation
Handshake:
- A request transfers when valid && ready in the same cycle.
- The requester holds rd and data stable while valid && !ready.

Arbitration:
- At most one grant per cycle.
- If exactly one requester is valid, it is granted.
- If both are valid, grant the index that is not rr_last.
- On every grant, rr_last becomes the granted index.
- ready is combinational from valid and rr_last; it is 0 while rst = 1.

Output stage, updated every cycle:
- On a grant with rd != 0: we = 1, rw = rd, busw = data.
- Otherwise: we = 0, and rw/busw hold their previous values.
- A grant with rd = 0 is accepted and discarded: we stays 0 and busy is unchanged.

Scoreboard:
- A grant for rd clears busy[rd].
- claim_valid with claim_rd != 0 sets busy[claim_rd]. A claim to register 0 is ignored.
- If a claim and a grant-clear hit the same register in the same cycle, the set wins (new producer).
- Claims and grants for different registers apply independently in the same cycle.
- stall = hazA || hazB.
- hazX = (rX != 0) && (busy[rX] || (we && rw == rX)).
- The `we` term covers the cycle in which the register file has not yet latched the write.

Reset values:
- we = 0, rw = 0, busw = 0.
- busy = 0, hence stall = 0.
- rr_last = 1, so req0 wins the first contention.
- Reset asserted mid-operation discards any registered write (we forced to 0 at that edge) and clears all busy bits. Requests presented during reset are not accepted.

## Timing
- Grant to we/rw/busw valid: 1 cycle. The register file commits at the following edge.
- Grant to busy bit clear: 1 cycle (same edge as the output registers).
- Claim to busy bit set and stall visible: 1 cycle.
- stall, req0_ready and req1_ready are combinational from current inputs and state. stall has no path from the req*/claim inputs.
- Sustained throughput: one write per cycle. Under continuous contention the grants alternate req0, req1, req0, and so on.
- No requester waits more than 1 cycle while the other is valid.

## Structure
Shared package holds:
- XLEN and AW defaults, and NUM_REGS = 2**AW
- REQ_ALU = 0, REQ_LD = 1 index constants
- ZERO_REG = 0

Sub-module rr_arb2 contains:
- the 2-way round-robin arbiter
- inputs: clk, rst, valid[1:0]
- outputs: grant[1:0]
- its own rr_last register

The top level holds the output registers, the scoreboard vector and the hazard logic.

## Test plan
- Reset: hold rst high 2 cycles with both requests valid → ready0 = ready1 = 0, we = 0, busy = 0, stall = 0. After release, req0 granted first.
- Contention: both valid continuously, req0 rd = 3 with data 0x11111111, req1 rd = 4 with data 0x22222222 → grants alternate 0, 1, 0, 1. we = 1 every cycle from cycle 2; rw sequence 3, 4, 3, 4.
- Scoreboard: claim rd = 7; next cycle ra = 7 → stall = 1. Grant req1 rd = 7 data 0xDEADBEEF → busy[7] = 0 at the next edge. stall stays 1 that cycle via we/rw, then drops to 0.
- Zero register: claim rd = 0 and grant req0 rd = 0 data 0xFFFFFFFF → busy = 0, we = 0, req0_ready = 1, and ra = 0 never stalls.
- Same-cycle claim and clear: busy[9] = 1; claim rd = 9 and grant rd = 9 in the same cycle → busy[9] = 1 afterwards and we = 1 with rw = 9.
- Reset mid-write: grant req0 rd = 5, then assert rst on the next edge → we = 0 and busy = 0 after that edge, and no write is issued.
